mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Parametrised N-channel memory front end for the XPU simulation top; serves the
//  icache (ch0) and dcache (ch1) fetch/load/store paths, plus extra agents if NUM_CH>2.
//  - Round-robin arbitration grants one request per cycle into a single word-addressed array.
//  - Responses leave through a fixed-latency pipeline, tagged back to the originating channel.
//  - Replaces the ad-hoc icache/dcache addr/valid -> data/valid wiring with a handshaked interface.
// PARAMETERS
//  NUM_CH    2     number of requesting channels (>=1)
//  ADDR_W    64    byte address width
//  DATA_W    64    word width; multiple of 8
//  DEPTH     4096  number of DATA_W words in the array; power of 2
//  LATENCY   2     cycles from grant to resp_valid (>=1)
// PORTS
//  clk        in   1                  clock
//  rst        in   1                  synchronous reset, active-low
//  req_valid  in   NUM_CH             per-channel request valid
//  req_ready  out  NUM_CH             per-channel grant; one-hot or zero
//  req_addr   in   NUM_CH*ADDR_W      byte address; ch i uses slice [i*ADDR_W +: ADDR_W]
//  req_we     in   NUM_CH             1 = write, 0 = read
//  req_wdata  in   NUM_CH*DATA_W      write data
//  req_wstrb  in   NUM_CH*DATA_W/8    byte write enables
//  resp_valid out  NUM_CH             one-cycle response pulse per channel
//  resp_data  out  NUM_CH*DATA_W      read data; 0 for writes and errors
//  resp_err   out  NUM_CH             address out of range
// BEHAVIOUR
//  Reset (rst==0 at posedge):
//   - rr_ptr <= 0; every pipeline stage valid <= 0.
//   - resp_valid, resp_data, resp_err <= 0.
//   - req_ready is 0 while rst==0; array contents are not cleared.
//  Arbitration (combinational):
//   - Grant the first channel with req_valid=1, searching rr_ptr, rr_ptr+1, ... mod NUM_CH.
//   - req_ready[g]=1 for the granted channel only; a transfer occurs when req_valid & req_ready.
//   - After a transfer, rr_ptr <= (g+1) mod NUM_CH; with no transfer, rr_ptr holds.
//   - Requesters hold addr/we/wdata/wstrb stable until ready (AXI-style); no combinational
//     path from req_ready back into req_valid is permitted.
//  Access, in the grant cycle:
//   - Word index = addr[ADDR_W-1 : log2(DATA_W/8)].
//   - Index >= DEPTH -> error: no array write; resp_err=1 and resp_data=0 at response time.
//   - Misaligned low bits are ignored.
//   - Write: bytes with wstrb=1 are updated at the grant clock edge.
//   - Read: data is sampled at the grant edge, so a write granted in cycle t is visible to a
//     read granted in cycle t+1.
//  Response pipeline:
//   - LATENCY stages carry {valid, ch id, err, data}.
//   - The response for a transfer at edge t asserts resp_valid[ch] for exactly one cycle,
//     registered, starting LATENCY cycles after edge t.
//   - Only the owning channel's slices change; other channels' resp_data hold their previous value.
//   - Write responses: resp_valid=1, resp_data=0 (ack only).
//   - Responses are always accepted (no resp backpressure); throughput is 1 request/cycle total.
//   - Ordering is global grant order; per-channel responses are in request order.
//  Boundary cases:
//   - All channels valid every cycle: strict rotation 0,1,..,NUM_CH-1,0; no starvation,
//     wait <= NUM_CH-1 cycles.
//   - NUM_CH==1: rr_ptr stays 0; req_ready = req_valid whenever out of reset.
//   - Reset mid-operation: in-flight responses are discarded and no resp_valid fires for them;
//     array writes already committed persist.
//   - Same address written by one channel and read by another in consecutive cycles:
//     grant order decides the result.
// TESTING
//  1 Reset: hold rst=0 for 3 cycles with all req_valid=1
//    -> req_ready=0, resp_valid=0, resp_data=0 throughout.
//  2 Write/read latency: ch1 writes 0xDEADBEEF_CAFEF00D to 0x80, wstrb=0xFF; next cycle ch1 reads 0x80
//    -> two resp_valid[1] pulses exactly LATENCY cycles after each grant; second resp_data=0xDEADBEEF_CAFEF00D.
//  3 Byte strobe: init word 0x0 = 0x1111_1111_1111_1111, write 0xFFFF_FFFF_FFFF_FFFF with wstrb=0x0F, read back
//    -> 0x1111_1111_FFFF_FFFF.
//  4 Fairness: ch0 and ch1 both valid for 6 cycles, rr_ptr=0 after reset
//    -> grants 0,1,0,1,0,1; responses appear in the same order.
//  5 Error: read at byte address DEPTH*DATA_W/8
//    -> resp_err=1, resp_data=0, array unchanged.
//  6 Reset mid-flight: grant a read, drop rst at the next edge
//    -> no resp_valid for that read; after release, a read of a previously written word returns its data.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin N-channel front end to a word-addressed array with a fixed-latency,
// channel-tagged response pipeline.
module mem_port_arbiter #(
   parameter int unsigned NUM_CH  = 2,
   parameter int unsigned ADDR_W  = 64,
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned DEPTH   = 4096,
   parameter int unsigned LATENCY = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_CH-1:0]            req_valid,
   output logic [NUM_CH-1:0]            req_ready,
   input  logic [NUM_CH*ADDR_W-1:0]     req_addr,
   input  logic [NUM_CH-1:0]            req_we,
   input  logic [NUM_CH*DATA_W-1:0]     req_wdata,
   input  logic [NUM_CH*DATA_W/8-1:0]   req_wstrb,
   output logic [NUM_CH-1:0]            resp_valid,
   output logic [NUM_CH*DATA_W-1:0]     resp_data,
   output logic [NUM_CH-1:0]            resp_err
);

   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned OFF_W  = $clog2(STRB_W);
   localparam int unsigned LOG_D  = $clog2(DEPTH);
   localparam int unsigned IDX_W  = (LOG_D > 0) ? LOG_D : 1;
   localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [CH_W-1:0]   rr_ptr;
   logic [CH_W-1:0]   grant_ch;
   logic              grant_any;
   logic              xfer;
   int unsigned       cand;

   logic [ADDR_W-1:0] g_addr;
   logic [ADDR_W-1:0] g_word;
   logic              g_we;
   logic [DATA_W-1:0] g_wdata;
   logic [STRB_W-1:0] g_wstrb;
   logic              g_err;
   logic [IDX_W-1:0]  g_idx;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [LATENCY-1:0] p_valid;
   logic [CH_W-1:0]    p_ch   [LATENCY];
   logic               p_err  [LATENCY];
   logic [DATA_W-1:0]  p_data [LATENCY];

   // First requesting channel at or after rr_ptr wins; nothing granted in reset.
   always_comb begin
      cand      = 0;
      grant_any = 1'b0;
      grant_ch  = '0;
      req_ready = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         cand = (32'(rr_ptr) + i) % NUM_CH;
         if (!grant_any && req_valid[cand]) begin
            grant_any = 1'b1;
            grant_ch  = CH_W'(cand);
         end
      end
      if (rst && grant_any) req_ready[grant_ch] = 1'b1;
   end

   assign xfer = rst && grant_any;

   // Granted request payload and word decode; low byte-offset bits are dropped.
   always_comb begin
      g_addr  = req_addr[32'(grant_ch)*ADDR_W +: ADDR_W];
      g_we    = req_we[grant_ch];
      g_wdata = req_wdata[32'(grant_ch)*DATA_W +: DATA_W];
      g_wstrb = req_wstrb[32'(grant_ch)*STRB_W +: STRB_W];
      g_word  = g_addr >> OFF_W;
      g_err   = (g_word >> LOG_D) != '0;
      g_idx   = g_word[IDX_W-1:0];
   end

   // Array contents survive reset.
   always_ff @(posedge clk) begin
      if (xfer && g_we && !g_err) begin
         for (int unsigned b = 0; b < STRB_W; b++) begin
            if (g_wstrb[b]) mem[g_idx][b*8 +: 8] <= g_wdata[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rr_ptr     <= '0;
         p_valid    <= '0;
         resp_valid <= '0;
         resp_data  <= '0;
         resp_err   <= '0;
      end else begin
         if (xfer) rr_ptr <= (grant_ch == CH_W'(NUM_CH-1)) ? '0 : grant_ch + CH_W'(1);

         // Read samples the pre-edge array; writes and errors carry zero data.
         p_valid[0] <= xfer;
         p_ch[0]    <= grant_ch;
         p_err[0]   <= g_err;
         p_data[0]  <= (g_we || g_err) ? '0 : mem[g_idx];
         for (int unsigned k = 1; k < LATENCY; k++) begin
            p_valid[k] <= p_valid[k-1];
            p_ch[k]    <= p_ch[k-1];
            p_err[k]   <= p_err[k-1];
            p_data[k]  <= p_data[k-1];
         end

         // Only the owning channel's response slices are updated.
         resp_valid <= '0;
         if (p_valid[LATENCY-1]) begin
            resp_valid[p_ch[LATENCY-1]] <= 1'b1;
            resp_err[p_ch[LATENCY-1]]   <= p_err[LATENCY-1];
            resp_data[32'(p_ch[LATENCY-1])*DATA_W +: DATA_W] <= p_data[LATENCY-1];
         end
      end
   end

endmodule
